seq_mult: RTL
=============

// Module: seq_mult
// PURPOSE
//   Parametrised sequential shift-add multiplier. It is the clocked successor to the
//   4x4 combinational array multiplier.
//   Computes P = A*B for WIDTH-bit operands, in unsigned or two's-complement signed mode,
//   using one partial product per clock. Sits between a valid/ready producer and a
//   valid/ready consumer, so datapaths can trade area for latency.
// PARAMETERS
//   WIDTH   4   operand width in bits, >= 2; product width is 2*WIDTH
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   in_valid    in   1        operands A, B, signed_mode valid
//   in_ready    out  1        block can accept operands
//   A           in   WIDTH    multiplicand
//   B           in   WIDTH    multiplier
//   signed_mode in   1        1: A, B, P two's complement; 0: unsigned
//   out_valid   out  1        P holds a finished product
//   out_ready   in   1        consumer accepts P
//   P           out  2*WIDTH  product
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, P=0,
//     internal accumulator/count=0. Applies immediately, including mid-CALC or in DONE.
//     Any in-flight result is discarded.
//   FSM states: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1, out_valid=0.
//     On in_valid&&in_ready: latch |A|, |B|, product sign and mode; acc=0; cnt=0; go to CALC.
//     In signed mode, |x| is the WIDTH-bit unsigned magnitude, so the most negative value
//     -2^(WIDTH-1) maps to 2^(WIDTH-1).
//     Product sign = A[MSB]^B[MSB] when signed_mode=1, else 0.
//   CALC: in_ready=0, out_valid=0. Each cycle:
//     if mb[0], acc += ma<<cnt;
//     mb >>= 1; cnt++.
//     After exactly WIDTH CALC cycles:
//       P <= sign ? -acc : acc (2*WIDTH bits, mod 2^(2*WIDTH));
//       go to DONE.
//     Adder width is 2*WIDTH; no overflow is possible.
//   DONE: out_valid=1, in_ready=0. P is held stable until out_valid&&out_ready.
//     On that handshake, go to IDLE next cycle. P keeps its value after the handshake,
//     and until the next result it is written.
//   Latency: acceptance at edge k gives out_valid=1 in the cycle after edge k+WIDTH.
//     With out_ready=1 the next accept is possible at edge k+WIDTH+2.
//   in_valid while in_ready=0 is ignored; A, B may change freely outside IDLE.
//   out_ready while out_valid=0 is ignored.
//   Zero operands take the full WIDTH cycles; there is no early termination.
//   signed_mode is sampled only at acceptance.
// TESTING
//   W=4 unsigned, A=3, B=5 -> P=8'h0F; out_valid first seen 4 cycles after accept.
//   W=4 unsigned, A=15, B=15 -> P=8'hE1 (225); A=10, B=5 -> 8'h32; A=1, B=8 -> 8'h08.
//   W=4 signed: A=-3 (4'hD), B=5 -> P=8'hF1; A=-8, B=-8 -> 8'h40; A=-8, B=7 -> 8'hC8.
//   Backpressure: hold out_ready=0 for 5 cycles in DONE -> P and out_valid stable,
//     in_ready=0; new in_valid with other operands is ignored.
//   Reset: drop rst_n in the 2nd CALC cycle -> outputs clear asynchronously (P=0,
//     out_valid=0, in_ready=1); after release, new op 6x7 -> 8'h2A.
//   W=8 unsigned 255x255 -> 16'hFE01 after 8 cycles; random signed/unsigned sweep vs
//     golden model.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, unsigned or
// two's-complement operands, valid/ready handshakes on both sides.
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ma, acc, acc_sum, p_r;
  logic [WIDTH-1:0] mb, abs_a, abs_b;
  logic [CW-1:0]   cnt;
  logic            neg, last;

  // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    abs_a   = (signed_mode && A[WIDTH-1]) ? -A : A;
    abs_b   = (signed_mode && B[WIDTH-1]) ? -B : B;
    acc_sum = acc + (mb[0] ? ma : '0);
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The multiplicand register shifts left each cycle, equivalent to ma<<cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      p_r <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        ma  <= PW'(abs_a);
        mb  <= abs_b;
        acc <= '0;
        cnt <= '0;
        neg <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
      end else if (state == CALC) begin
        acc <= acc_sum;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt + CW'(1);
        if (last) p_r <= neg ? -acc_sum : acc_sum;
      end
    end
  end

  assign P = p_r;

endmodule
